// File: rtl/i2c_master_byte_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : i2c_master_byte_ctrl_if
// Brief    : Request/response and PHY bit-command bundle for the byte sequencer
// Revision : 1.0 - initial release
// ============================================================================
interface i2c_master_byte_ctrl_if;
    logic       req_valid_i;
    logic       req_ready_o;
    logic       req_start_i;
    logic       req_stop_i;
    logic       req_read_i;
    logic       req_ack_i;
    logic [7:0] req_data_i;
    logic       rsp_valid_o;
    logic [7:0] rsp_data_o;
    logic       rsp_ack_o;
    logic       rsp_arb_lost_o;
    logic       rsp_timeout_o;
    logic       busy_o;
    logic [2:0] phy_cmd_o;
    logic       phy_data_o;
    logic       phy_data_i;
    logic       phy_cmd_done_i;
    logic       phy_arb_lost_i;
    logic       phy_bus_busy_i;

    // Sequencer side
    modport slave (
        input  req_valid_i, req_start_i, req_stop_i, req_read_i, req_ack_i, req_data_i,
               phy_data_i, phy_cmd_done_i, phy_arb_lost_i, phy_bus_busy_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_ack_o, rsp_arb_lost_o,
               rsp_timeout_o, busy_o, phy_cmd_o, phy_data_o
    );

    // Front end plus PHY side
    modport master (
        output req_valid_i, req_start_i, req_stop_i, req_read_i, req_ack_i, req_data_i,
               phy_data_i, phy_cmd_done_i, phy_arb_lost_i, phy_bus_busy_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_ack_o, rsp_arb_lost_o,
               rsp_timeout_o, busy_o, phy_cmd_o, phy_data_o
    );
endinterface
`default_nettype wire

// File: rtl/i2c_master_byte_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : i2c_master_byte_ctrl
// Brief    : Sequences START / 8 data bits / ACK / STOP bit commands to the PHY
// Revision : 1.0 - initial release
// ============================================================================
module i2c_master_byte_ctrl #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    i2c_master_byte_ctrl_if.slave bus
);
    localparam logic [2:0] C_CMD_NOP   = 3'd0;
    localparam logic [2:0] C_CMD_START = 3'd1;
    localparam logic [2:0] C_CMD_STOP  = 3'd2;
    localparam logic [2:0] C_CMD_WRITE = 3'd3;
    localparam logic [2:0] C_CMD_READ  = 3'd4;

    localparam int                  C_WDOG_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [C_WDOG_W-1:0] C_WDOG_LIMIT = C_WDOG_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_BUS = 3'd1,
        S_START    = 3'd2,
        S_BIT      = 3'd3,
        S_ACK      = 3'd4,
        S_STOP     = 3'd5,
        S_RESP     = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_cmd;
    logic [2:0]          w_cmd_nxt;
    logic                r_data;
    logic                w_data_nxt;
    logic [7:0]          r_shift;
    logic [7:0]          w_shift_nxt;
    logic [2:0]          r_bit_cnt;
    logic                r_own_bus;
    logic [C_WDOG_W-1:0] r_wdog;
    logic [C_WDOG_W-1:0] w_wdog_inc;
    logic                r_stop;
    logic                r_read;
    logic                r_ack_req;
    logic [7:0]          r_rsp_data;
    logic                r_rsp_ack;
    logic                r_rsp_arb;
    logic                r_rsp_timeout;

    logic w_accept;
    logic w_issued;
    logic w_done;
    logic w_arb;
    logic w_timeout;
    logic w_abort;
    logic w_read;

    assign w_accept   = (r_state == S_IDLE) && bus.req_valid_i;
    // A command counts as issued only once it is visible on phy_cmd_o
    assign w_issued   = (r_state inside {S_START, S_BIT, S_ACK, S_STOP}) && (r_cmd != C_CMD_NOP);
    assign w_arb      = bus.phy_arb_lost_i && (r_state != S_IDLE) && (r_state != S_RESP);
    assign w_done     = w_issued && bus.phy_cmd_done_i && !w_arb;
    assign w_wdog_inc = r_wdog + C_WDOG_W'(1);
    assign w_timeout  = (TIMEOUT_CYCLES != 0) && w_issued && !w_done && !w_arb
                        && (w_wdog_inc == C_WDOG_LIMIT);
    assign w_abort    = w_arb || w_timeout;
    assign w_read     = (r_state == S_IDLE) ? bus.req_read_i : r_read;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (bus.req_valid_i) w_state_nxt = bus.req_start_i ? S_WAIT_BUS : S_BIT;
            S_WAIT_BUS: if (!(bus.phy_bus_busy_i && !r_own_bus)) w_state_nxt = S_START;
            S_START:    if (w_done) w_state_nxt = S_BIT;
            S_BIT:      if (w_done && (r_bit_cnt == 3'd7)) w_state_nxt = S_ACK;
            S_ACK:      if (w_done) w_state_nxt = r_stop ? S_STOP : S_RESP;
            S_STOP:     if (w_done) w_state_nxt = S_RESP;
            S_RESP:     w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
        if (w_abort) begin
            w_state_nxt = S_RESP;
        end

        w_shift_nxt = r_shift;
        if (w_accept) begin
            w_shift_nxt = bus.req_data_i;
        end else if (w_done && (r_state == S_BIT)) begin
            w_shift_nxt = {r_shift[6:0], r_read ? bus.phy_data_i : 1'b0};
        end

        // A done (or abort) cycle always yields one NOP before the next command
        w_cmd_nxt  = C_CMD_NOP;
        w_data_nxt = 1'b1;
        if (!w_done && !w_abort) begin
            case (w_state_nxt)
                S_START: w_cmd_nxt = C_CMD_START;
                S_BIT: begin
                    if (w_read) begin
                        w_cmd_nxt = C_CMD_READ;
                    end else begin
                        w_cmd_nxt  = C_CMD_WRITE;
                        w_data_nxt = w_shift_nxt[7];
                    end
                end
                S_ACK: begin
                    if (w_read) begin
                        w_cmd_nxt  = C_CMD_WRITE;
                        w_data_nxt = r_ack_req;
                    end else begin
                        w_cmd_nxt = C_CMD_READ;
                    end
                end
                S_STOP:  w_cmd_nxt = C_CMD_STOP;
                default: w_cmd_nxt = C_CMD_NOP;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cmd         <= C_CMD_NOP;
            r_data        <= 1'b1;
            r_shift       <= 8'h00;
            r_bit_cnt     <= 3'd0;
            r_own_bus     <= 1'b0;
            r_wdog        <= '0;
            r_stop        <= 1'b0;
            r_read        <= 1'b0;
            r_ack_req     <= 1'b0;
            r_rsp_data    <= 8'h00;
            r_rsp_ack     <= 1'b0;
            r_rsp_arb     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_cmd   <= w_cmd_nxt;
            r_data  <= w_data_nxt;
            r_shift <= w_shift_nxt;

            if (w_accept) begin
                r_stop        <= bus.req_stop_i;
                r_read        <= bus.req_read_i;
                r_ack_req     <= bus.req_ack_i;
                r_bit_cnt     <= 3'd0;
                r_rsp_ack     <= 1'b0;
                r_rsp_arb     <= 1'b0;
                r_rsp_timeout <= 1'b0;
            end

            if (w_done && (r_state == S_BIT)) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_done && (r_state == S_ACK)) begin
                r_rsp_ack <= r_read ? r_ack_req : bus.phy_data_i;
            end
            if (w_arb) begin
                r_rsp_arb <= 1'b1;
            end
            if (w_timeout) begin
                r_rsp_timeout <= 1'b1;
            end

            if (w_abort) begin
                r_own_bus <= 1'b0;
            end else if (w_done && (r_state == S_START)) begin
                r_own_bus <= 1'b1;
            end else if (w_done && (r_state == S_STOP)) begin
                r_own_bus <= 1'b0;
            end

            if (!w_issued || w_done || (w_state_nxt != r_state)) begin
                r_wdog <= '0;
            end else begin
                r_wdog <= w_wdog_inc;
            end

            if ((w_state_nxt == S_RESP) && (r_state != S_RESP) && r_read) begin
                r_rsp_data <= w_shift_nxt;
            end
        end
    end

    assign bus.req_ready_o    = (r_state == S_IDLE);
    assign bus.busy_o         = (r_state != S_IDLE);
    assign bus.rsp_valid_o    = (r_state == S_RESP);
    assign bus.rsp_data_o     = r_rsp_data;
    assign bus.rsp_ack_o      = r_rsp_ack;
    assign bus.rsp_arb_lost_o = r_rsp_arb;
    assign bus.rsp_timeout_o  = r_rsp_timeout;
    assign bus.phy_cmd_o      = r_cmd;
    assign bus.phy_data_o     = r_data;

endmodule
`default_nettype wire
